// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter: shares SDRAM port B between the game CPU and the ROM loader byte stream.
// Optional feature macro: ROM_LOAD_CHECKSUM_EN builds a 16-bit wrapping sum of retired bytes.

module rom_load_arbiter #(
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] LOAD_BASE   = '0,
  parameter int                HOLD_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              loading,
  input  logic [7:0]        loader_do,
  input  logic              loader_do_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_dout,
  input  logic              mem_slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] load_bytes,
  output logic              load_done,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_HOLD, S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic             loading_q;

  logic [7:0]       fifo_mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       count;

  logic load_rise, writing, fifo_empty, fifo_full;
  logic wr_req, pop, push, push_ok, drop;
  logic [7:0] fifo_head;

  assign load_rise  = loading & ~loading_q;
  assign writing    = (state == S_LOAD) || (state == S_FLUSH);
  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign wr_req     = writing & ~fifo_empty;
  assign pop        = wr_req & mem_slot;
  assign push       = (state == S_LOAD) & loader_do_valid;
  // A push at full survives only when the head leaves in the same cycle.
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_HOLD;
      hold_cnt  <= CNT_W'(HOLD_CYCLES);
      loading_q <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_nx;
      loading_q <= loading;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    load_done   = 1'b0;
    if (load_rise) begin
      state_nx = S_LOAD;
    end else begin
      unique case (state)
        S_LOAD: if (!loading) state_nx = S_FLUSH;
        S_FLUSH: begin
          if (fifo_empty) begin
            state_nx    = S_HOLD;
            hold_cnt_nx = CNT_W'(HOLD_CYCLES);
            load_done   = 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) state_nx = S_IDLE;
          else                hold_cnt_nx = hold_cnt - CNT_W'(1);
        end
        S_IDLE: ;
        default: state_nx = S_HOLD;
      endcase
    end
  end

  always_comb begin
    mem_addr = LOAD_BASE + load_bytes;
    mem_oe   = 1'b0;
    mem_we   = wr_req;
    mem_din  = wr_req ? fifo_head : 8'h00;
    cpu_hold = 1'b1;
    if (state == S_IDLE) begin
      mem_addr = cpu_addr;
      mem_oe   = cpu_read;
      mem_we   = cpu_write;
      mem_din  = cpu_dout;
      cpu_hold = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      load_bytes <= '0;
      overflow   <= 1'b0;
    end else if (load_rise) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      load_bytes <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 2'd1;
        load_bytes <= load_bytes + ADDR_W'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !load_rise) fifo_mem[wr_ptr] <= loader_do;
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        checksum <= '0;
    else if (load_rise) checksum <= '0;
    else if (pop)       checksum <= checksum + {8'h00, fifo_head};
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Self-checking bench for rom_load_arbiter: directed scenarios plus randomized loads
// compared cycle by cycle against a queue-based reference model.

module tb_rom_load_arbiter;

  localparam int                ADDR_W      = 22;
  localparam logic [ADDR_W-1:0] LOAD_BASE   = 22'h100000;
  localparam int                HOLD_CYCLES = 255;

  logic              clk;
  logic              resetn;
  logic              loading;
  logic [7:0]        loader_do;
  logic              loader_do_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_read;
  logic              cpu_write;
  logic [7:0]        cpu_dout;
  logic              mem_slot;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_oe;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic              cpu_hold;
  logic [ADDR_W-1:0] load_bytes;
  logic              load_done;
  logic              overflow;
  logic [15:0]       checksum;

  rom_load_arbiter #(
    .ADDR_W      (ADDR_W),
    .LOAD_BASE   (LOAD_BASE),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .loading         (loading),
    .loader_do       (loader_do),
    .loader_do_valid (loader_do_valid),
    .cpu_addr        (cpu_addr),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_dout        (cpu_dout),
    .mem_slot        (mem_slot),
    .mem_addr        (mem_addr),
    .mem_oe          (mem_oe),
    .mem_we          (mem_we),
    .mem_din         (mem_din),
    .cpu_hold        (cpu_hold),
    .load_bytes      (load_bytes),
    .load_done       (load_done),
    .overflow        (overflow),
    .checksum        (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns port B, bytes waiting, bytes written, sticky flags.
  localparam int M_HOLD = 0, M_IDLE = 1, M_LOAD = 2, M_FLUSH = 3;
  int          m_mode;
  byte unsigned m_q[$];
  int          m_written;
  bit          m_ovf;
  int          m_sum;
  bit          m_prev;
  longint      cyc;
  longint      idle_at;

  int n_checks;
  int n_fail;

  int slot_period;
  bit force_slot;
  bit seen_hold;
  bit seen_done;
  int done_count;
  logic [ADDR_W-1:0] obs_addr[$];
  logic [7:0]        obs_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_HOLD;
    m_q.delete();
    m_written = 0;
    m_ovf     = 1'b0;
    m_sum     = 0;
    m_prev    = 1'b0;
    idle_at   = cyc + 1 + HOLD_CYCLES;
  endtask

  task automatic model_update();
    int sz;
    bit pop;
    if (!resetn) begin
      model_reset();
    end else begin
      sz = m_q.size();
      if (loading && !m_prev) begin
        m_mode    = M_LOAD;
        m_q.delete();
        m_written = 0;
        m_ovf     = 1'b0;
        m_sum     = 0;
      end else begin
        pop = (m_mode == M_LOAD || m_mode == M_FLUSH) && sz > 0 && mem_slot;
        if (pop) begin
          m_sum += m_q[0];
          void'(m_q.pop_front());
          m_written++;
        end
        if (m_mode == M_LOAD && loader_do_valid) begin
          if (sz == 4 && !pop) m_ovf = 1'b1;
          else                 m_q.push_back(loader_do);
        end
        case (m_mode)
          M_LOAD:  if (!loading) m_mode = M_FLUSH;
          M_FLUSH: if (sz == 0) begin
                     m_mode  = M_HOLD;
                     idle_at = cyc + HOLD_CYCLES + 1;
                   end
          M_HOLD:  if (cyc >= idle_at) m_mode = M_IDLE;
          default: ;
        endcase
      end
      m_prev = loading;
    end
    cyc++;
  endtask

  task automatic sample_and_check();
    logic [ADDR_W-1:0] ea;
    bit ewe;
    int esum;
    seen_hold = cpu_hold;
    seen_done = load_done;
    if (load_done) done_count++;
    if (mem_slot && mem_we && cpu_hold) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_din);
    end
    if (resetn) begin
      if (m_mode == M_IDLE) begin
        check("idle_hold", 32'(cpu_hold), 0);
        check("idle_addr", 32'(mem_addr), 32'(cpu_addr));
        check("idle_oe", 32'(mem_oe), 32'(cpu_read));
        check("idle_we", 32'(mem_we), 32'(cpu_write));
        check("idle_din", 32'(mem_din), 32'(cpu_dout));
      end else begin
        ea  = LOAD_BASE + ADDR_W'(m_written);
        ewe = (m_mode == M_LOAD || m_mode == M_FLUSH) && m_q.size() > 0;
        check("busy_hold", 32'(cpu_hold), 1);
        check("busy_oe", 32'(mem_oe), 0);
        check("busy_we", 32'(mem_we), 32'(ewe));
        check("busy_addr", 32'(mem_addr), 32'(ea));
        if (ewe) check("busy_din", 32'(mem_din), 32'(m_q[0]));
      end
      check("load_done", 32'(load_done), 32'(m_mode == M_FLUSH && m_q.size() == 0));
      check("load_bytes", 32'(load_bytes), 32'(ADDR_W'(m_written)));
      check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ROM_LOAD_CHECKSUM_EN
      esum = m_sum & 16'hFFFF;
`else
      esum = 0;
`endif
      check("checksum", 32'(checksum), 32'(esum));
    end
  endtask

  task automatic tick();
    cpu_addr  = ADDR_W'($urandom);
    cpu_read  = 1'($urandom);
    cpu_write = 1'($urandom);
    cpu_dout  = 8'($urandom);
    mem_slot  = (force_slot ||
                 (slot_period > 0 && (cyc % slot_period) == 0) ||
                 (slot_period < 0 && $urandom_range(0, 2) == 0)) ? 1'b1 : 1'b0;
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    loader_do       = b;
    loader_do_valid = 1'b1;
    tick();
    loader_do_valid = 1'b0;
    loader_do       = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!seen_done && n < 200);
    check(tag, 32'(seen_done), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (seen_hold && n < 400);
    check(tag, 32'(seen_hold), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int choices[5];
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    choices  = '{-1, 1, 2, 3, 5};
    resetn   = 1'b0;
    loading  = 1'b0;
    loader_do = 8'h00;
    loader_do_valid = 1'b0;
    slot_period = 0;
    force_slot  = 1'b0;
    done_count  = 0;
    model_reset();

    // Reset values, then the post-reset CPU hold length.
    repeat (2) tick();
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_we", 32'(mem_we), 0);
    check("rst_oe", 32'(mem_oe), 0);
    check("rst_addr", 32'(mem_addr), 32'(LOAD_BASE));
    check("rst_din", 32'(mem_din), 0);
    check("rst_bytes", 32'(load_bytes), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_sum", 32'(checksum), 0);
    resetn = 1'b1;
    n = 0;
    do begin
      tick();
      if (seen_hold) n++;
    end while (seen_hold && n < 400);
    check("rst_hold_cycles", 32'(n), 32'(HOLD_CYCLES + 1));
    repeat (4) tick();

    // Sequential load of three bytes with a slot every 4 cycles.
    slot_period = 4;
    obs_addr.delete(); obs_data.delete();
    done_count = 0;
    loading = 1'b1;
    tick();
    strobe(8'h11); tick();
    strobe(8'h22); tick(); tick();
    strobe(8'h33); tick();
    loading = 1'b0;
    wait_done("seq_done_seen");
    repeat (3) tick();
    check("seq_writes", 32'(obs_addr.size()), 3);
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      check("seq_addr", 32'(obs_addr[i]), 32'(LOAD_BASE) + 32'(i));
      check("seq_data", 32'(obs_data[i]), 32'h11 * (i + 1));
    end
    check("seq_bytes", 32'(load_bytes), 3);
    check("seq_done_pulses", 32'(done_count), 1);
`ifdef ROM_LOAD_CHECKSUM_EN
    check("seq_sum", 32'(checksum), 32'h0066);
`else
    check("seq_sum", 32'(checksum), 0);
`endif
    wait_idle("seq_idle");

    // Overflow: six back-to-back strobes with no slots.
    slot_period = 0;
    obs_data.delete(); obs_addr.delete();
    loading = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) strobe(8'(i));
    tick();
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_bytes_pre", 32'(load_bytes), 0);
    slot_period = 2;
    loading = 1'b0;
    wait_done("ovf_done_seen");
    check("ovf_bytes", 32'(load_bytes), 4);
    check("ovf_writes", 32'(obs_data.size()), 4);
    for (int i = 0; i < 4 && i < obs_data.size(); i++)
      check("ovf_data", 32'(obs_data[i]), 32'(i + 1));

    // Restart during HOLD, then push and pop together at full.
    slot_period = 0;
    obs_data.delete(); obs_addr.delete();
    loading = 1'b1;
    tick();
    tick();
    check("rst_load_bytes_clear", 32'(load_bytes), 0);
    check("rst_load_ovf_clear", 32'(overflow), 0);
    check("rst_load_hold", 32'(seen_hold), 1);
    for (int i = 0; i < 4; i++) strobe(8'hA0 + 8'(i));
    force_slot = 1'b1;
    strobe(8'hA4);
    force_slot = 1'b0;
    tick();
    check("full_pp_ovf", 32'(overflow), 0);
    check("full_pp_bytes", 32'(load_bytes), 1);
    check("restart_addr", 32'(obs_addr.size() > 0 ? obs_addr[0] : '1), 32'(LOAD_BASE));
    check("restart_hold", 32'(seen_hold), 1);
    slot_period = 3;
    loading = 1'b0;
    wait_done("full_pp_done_seen");
    check("full_pp_total", 32'(load_bytes), 5);
    check("full_pp_last", 32'(obs_data.size() == 5 ? obs_data[4] : 8'h00), 32'hA4);
    wait_idle("full_pp_idle");

    // Flush: loading drops with three bytes still queued.
    slot_period = 0;
    done_count = 0;
    loading = 1'b1;
    tick();
    strobe(8'h5A); strobe(8'hC3); strobe(8'h0F);
    loading = 1'b0;
    repeat (6) tick();
    check("flush_wait_done", 32'(done_count), 0);
    for (int i = 0; i < 3; i++) begin
      force_slot = 1'b1;
      tick();
      force_slot = 1'b0;
      if (i < 2) begin
        tick(); tick();
        check("flush_early_done", 32'(done_count), 0);
      end
    end
    tick();
    check("flush_done_pulse", 32'(seen_done), 1);
    tick();
    check("flush_done_once", 32'(done_count), 1);
    check("flush_hold", 32'(seen_hold), 1);
    check("flush_bytes", 32'(load_bytes), 3);
    wait_idle("flush_idle");

    // Randomized loads, sometimes restarting straight out of HOLD.
    for (int it = 0; it < 12; it++) begin
      int nb;
      slot_period = choices[$urandom_range(0, 4)];
      nb = $urandom_range(0, 12);
      loading = 1'b1;
      tick();
      if (nb == 0) begin
        loading = 1'b0;
      end else begin
        for (int b = 0; b < nb; b++) begin
          repeat ($urandom_range(0, 2)) tick();
          strobe(8'($urandom));
        end
        repeat ($urandom_range(0, 3)) tick();
        loading = 1'b0;
      end
      wait_done("rand_done_seen");
      if ($urandom_range(0, 1) == 1) wait_idle("rand_idle");
    end

    // Asynchronous reset in the middle of a load.
    slot_period = 2;
    loading = 1'b1;
    tick();
    strobe(8'h71); strobe(8'h72); strobe(8'h73);
    slot_period = 0;
    strobe(8'h74); strobe(8'h75);
    #2 resetn = 1'b0;
    #1;
    check("abort_bytes", 32'(load_bytes), 0);
    check("abort_we", 32'(mem_we), 0);
    check("abort_hold", 32'(cpu_hold), 1);
    check("abort_addr", 32'(mem_addr), 32'(LOAD_BASE));
    loading = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    wait_idle("abort_idle");
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_load_arbiter.md
# rom_load_arbiter

Shares SDRAM port B between the game CPU and the iosys ROM loader byte stream. While a ROM is loading, it buffers loader bytes in a 4-entry FIFO and writes them to sequential SDRAM addresses, one write per SDRAM port-B slot. After loading it holds the CPU in reset for a fixed period, then returns port B to the CPU. It sits between the iosys/loader outputs, the core's CPU memory port and the `sdram_gametank` port B.

## Interface
- `ADDR_W`, 22: SDRAM byte-address width.
- `LOAD_BASE`, 0: SDRAM address of the first loaded byte.
- `HOLD_CYCLES`, 255: post-load CPU reset hold, in clk cycles.

- `clk` in 1: core clock (21.477 MHz domain).
- `resetn` in 1: reset, asynchronous, active-low.
- `loading` in 1: level from iosys. 0→1 starts a load; 1→0 ends it.
- `loader_do` in 8: loader data byte.
- `loader_do_valid` in 1: one-cycle strobe that qualifies `loader_do`.
- `cpu_addr` in ADDR_W, `cpu_read` in 1, `cpu_write` in 1, `cpu_dout` in 8: CPU memory request.
- `mem_slot` in 1: one-cycle pulse; port B samples the current request on this cycle.
- `mem_addr` out ADDR_W, `mem_oe` out 1, `mem_we` out 1, `mem_din` out 8: port-B request.
- `cpu_hold` out 1: holds the core in reset.
- `load_bytes` out ADDR_W: number of bytes written to SDRAM in the current or last load.
- `load_done` out 1: one-cycle pulse when the final byte has been written.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `checksum` out 16: see Configuration.

## Operation
- States: HOLD, IDLE, LOAD, FLUSH.
- **IDLE**
  - `mem_*` pass `cpu_*` combinationally.
  - `cpu_hold` = 0.
- **LOAD, FLUSH, HOLD**
  - CPU requests are ignored.
  - `cpu_hold` = 1.
  - `mem_oe` = 0.
- **FIFO**
  - 4 entries, 2-bit pointers, 3-bit count.
  - Push on `loader_do_valid` while in LOAD.
  - Pop on `mem_slot` while `mem_we` = 1.
  - Push and pop in the same cycle at full: both take effect; no overflow.
  - Push at full without a pop: byte is dropped and `overflow` is set.
- **LOAD/FLUSH write path**
  - `mem_we` = FIFO not empty.
  - `mem_addr` = `LOAD_BASE` + `load_bytes`, mod 2^ADDR_W.
  - `mem_din` = FIFO head.
  - The request is held unchanged until `mem_slot`. On `mem_slot`, `load_bytes` increments.
- **Transitions**
  - Rising edge of `loading` in any state → LOAD. On entry:
    - FIFO clears;
    - `load_bytes`, `overflow` and `checksum` clear;
    - the HOLD counter is abandoned.
  - LOAD with `loading` = 0 → FLUSH.
  - FLUSH with FIFO empty → HOLD. The same cycle pulses `load_done` and loads the hold counter with `HOLD_CYCLES`.
  - HOLD with counter = 0 → IDLE. Otherwise the counter decrements each cycle.
- **Edge detection:** `loading` is compared against its own value registered one cycle earlier.
- **Loader strobes outside LOAD:** a `loader_do_valid` in FLUSH, HOLD or IDLE is ignored.

## Timing
- **Reset values**
  - State HOLD, hold counter = `HOLD_CYCLES`.
  - `cpu_hold` = 1.
  - `mem_we` = `mem_oe` = 0.
  - `mem_addr` = `LOAD_BASE`, `mem_din` = 0.
  - `load_bytes` = 0, `load_done` = 0, `overflow` = 0, `checksum` = 0.
  - `loading` edge register = 0.
- **Reset deassertion:** after release, IDLE is reached `HOLD_CYCLES`+1 cycles later.
- **Write latency**
  - A byte strobed at edge N appears on `mem_we`/`mem_din` after edge N.
  - It is retired at the first `mem_slot` cycle from N+1 onward.
- **FIFO empty:** `mem_slot` with `mem_we` = 0 has no effect.
- **`load_done`:** asserted for exactly one cycle, in the cycle FLUSH exits.
- **`loading` pulse shorter than 2 cycles:** still enters LOAD, then FLUSH, then HOLD.
- **Reset mid-load:** asynchronously aborts the load; FIFO contents are lost.

## Configuration
- `ROM_LOAD_CHECKSUM_EN`
  - **Defined:** `checksum` is a 16-bit wrapping sum of every byte retired to SDRAM (zero-extended). It clears on LOAD entry and holds after the load.
  - **Undefined:** `checksum` is tied to 0 and the adder is not built.

## Test plan
- **Reset:** deassert `resetn` with `HOLD_CYCLES`=255 → `cpu_hold`=1 for 256 cycles, then 0, and `mem_*` follow `cpu_*`.
- **Sequential load:**
  - Stimulus: `LOAD_BASE`=0x100000. Load bytes 0x11, 0x22, 0x33 with `mem_slot` every 4 cycles.
  - Required response:
    - writes land at 0x100000–0x100002 in order;
    - `load_bytes`=3;
    - `load_done` pulses once;
    - `checksum`=0x0066 with the macro, 0 without.
- **Overflow:** 6 strobes on consecutive cycles with no `mem_slot` → 4 bytes written, `overflow`=1, `load_bytes`=4.
- **Full push+pop:** FIFO full, `loader_do_valid` and `mem_slot` in the same cycle → count stays 4, `overflow`=0.
- **Flush:** drop `loading` with 3 bytes queued → state stays FLUSH until the third `mem_slot`, then `load_done` pulses and HOLD begins.
- **Restart:** raise `loading` during HOLD → `load_bytes` is cleared, the next write goes to `LOAD_BASE`, and `cpu_hold` stays 1 throughout.
